// File: rtl/uart_word_packer_if.sv
// Purpose: bundles the byte-in / word-out signals of uart_word_packer.
// Latency: none, wiring only.
// Backpressure: out_ready from the consumer; the byte side has none (rx_valid is a strobe).
interface uart_word_packer_if #(
  parameter int BYTES_PER_WORD = 2,
  parameter int FIFO_DEPTH     = 4
);
  logic                          rx_valid;
  logic [7:0]                    rx_data;
  logic                          flush;
  logic [8*BYTES_PER_WORD-1:0]   out_data;
  logic                          out_valid;
  logic                          out_ready;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;
  logic                          overflow;
  logic                          overflow_clr;
  logic                          timeout_err;

  // Byte source / word consumer side.
  modport master (
    output rx_valid, rx_data, flush, out_ready, overflow_clr,
    input  out_data, out_valid, fifo_count, overflow, timeout_err
  );

  // Packer side.
  modport slave (
    input  rx_valid, rx_data, flush, out_ready, overflow_clr,
    output out_data, out_valid, fifo_count, overflow, timeout_err
  );
endinterface

// File: rtl/uart_word_packer.sv
// Purpose: packs BYTES_PER_WORD UART bytes into a word and queues it in a small FIFO.
// Latency: last byte strobe in cycle N -> word at FIFO head (out_valid) in cycle N+1.
// Backpressure: out_valid/out_ready on the word side; a word completed into a full FIFO is dropped and flagged.
module uart_word_packer #(
  parameter int BYTES_PER_WORD = 2,
  parameter int FIFO_DEPTH     = 4,
  parameter bit BIG_ENDIAN     = 1'b0,
  parameter int TIMEOUT_CYCLES = 0
) (
  input logic               clk,
  input logic               rst_n,
  uart_word_packer_if.slave bus
);
  localparam int W  = 8 * BYTES_PER_WORD;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [IW-1:0] LAST_IDX  = IW'(BYTES_PER_WORD - 1);
  localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

  logic [IW-1:0] idx_q;
  logic [IW-1:0] byte_pos;
  logic [TW-1:0] tmo_cnt_q;
  logic [W-1:0]  asm_q;
  logic [W-1:0]  word_next;
  logic          accept;
  logic          word_done;
  logic          tmo_expire;
  logic          timeout_err_q;

  logic [W-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          pop;
  logic          full;
  logic          push_ok;
  logic          ovf_set;
  logic          overflow_q;

  // A byte is taken unless flush discards it; the word completes on the last index.
  assign accept     = bus.rx_valid && !bus.flush;
  assign word_done  = accept && (idx_q == LAST_IDX);
  // Expiry yields to an arriving byte and to flush, so only an idle partial word times out.
  assign tmo_expire = (TIMEOUT_CYCLES > 0) && (idx_q != '0) && !bus.rx_valid &&
                      !bus.flush && (tmo_cnt_q == TMO_LIMIT);

  // Merge the incoming byte into the assembly register at its byte-order position.
  always_comb begin
    byte_pos  = BIG_ENDIAN ? (LAST_IDX - idx_q) : idx_q;
    word_next = asm_q;
    word_next[8*byte_pos +: 8] = bus.rx_data;
  end

  // Byte index and assembly register; stale bytes are simply overwritten by the next word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      asm_q <= '0;
    end else if (bus.flush) begin
      idx_q <= '0;
    end else if (accept) begin
      asm_q <= word_next;
      idx_q <= word_done ? '0 : idx_q + 1'b1;
    end else if (tmo_expire) begin
      idx_q <= '0;
    end
  end

  // Inter-byte idle counter, running only while a partial word is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      timeout_err_q <= tmo_expire;
      if ((TIMEOUT_CYCLES == 0) || bus.flush || bus.rx_valid || tmo_expire || (idx_q == '0))
        tmo_cnt_q <= '0;
      else
        tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
  end

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push when popped.
  assign pop     = (count_q != '0) && bus.out_ready;
  assign full    = (count_q == FULL_CNT);
  assign push_ok = word_done && (!full || pop);
  assign ovf_set = word_done && full && !pop;

  // Word storage and pointers; storage is cleared so out_data reads zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr_q] <= word_next;
        wr_ptr_q      <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Occupancy: simultaneous push and pop leave it unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky drop flag; a new drop beats a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                overflow_q <= 1'b0;
    else if (ovf_set)          overflow_q <= 1'b1;
    else if (bus.overflow_clr) overflow_q <= 1'b0;
  end

  assign bus.out_data    = mem[rd_ptr_q];
  assign bus.out_valid   = (count_q != '0);
  assign bus.fifo_count  = count_q;
  assign bus.overflow    = overflow_q;
  assign bus.timeout_err = timeout_err_q;
endmodule

// File: tb/tb_uart_word_packer.sv
// Purpose: directed self-checking bench for uart_word_packer (LE/timeout and BE instances).
// Latency: checks sampled 1 time unit after the rising edge.
// Backpressure: out_ready driven directly per scenario.
module tb_uart_word_packer;
  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  uart_word_packer_if #(.BYTES_PER_WORD(2), .FIFO_DEPTH(4)) ifa ();
  uart_word_packer_if #(.BYTES_PER_WORD(4), .FIFO_DEPTH(4)) ifb ();

  uart_word_packer #(
    .BYTES_PER_WORD(2), .FIFO_DEPTH(4), .BIG_ENDIAN(1'b0), .TIMEOUT_CYCLES(10)
  ) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));

  uart_word_packer #(
    .BYTES_PER_WORD(4), .FIFO_DEPTH(4), .BIG_ENDIAN(1'b1), .TIMEOUT_CYCLES(0)
  ) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [7:0] b);
    ifa.rx_valid = 1'b1;
    ifa.rx_data  = b;
    step();
    ifa.rx_valid = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] b);
    ifb.rx_valid = 1'b1;
    ifb.rx_data  = b;
    step();
    ifb.rx_valid = 1'b0;
  endtask

  task automatic send_word_a(input logic [15:0] w);
    send_a(w[7:0]);
    send_a(w[15:8]);
  endtask

  logic [15:0] ovf_words [5] = '{16'hA010, 16'hA111, 16'hA212, 16'hA313, 16'hA414};
  logic [15:0] pp_words  [4] = '{16'hA111, 16'hA212, 16'hA313, 16'hB5B4};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int pulses;
    int first;
    rst_n = 1'b0;
    ifa.rx_valid = 1'b0; ifa.rx_data = '0; ifa.flush = 1'b0; ifa.out_ready = 1'b0; ifa.overflow_clr = 1'b0;
    ifb.rx_valid = 1'b0; ifb.rx_data = '0; ifb.flush = 1'b0; ifb.out_ready = 1'b0; ifb.overflow_clr = 1'b0;
    repeat (3) step();

    // Reset values on both instances.
    check("rst_a_valid", ifa.out_valid, 0);
    check("rst_a_data",  ifa.out_data, 0);
    check("rst_a_count", ifa.fifo_count, 0);
    check("rst_a_ovf",   ifa.overflow, 0);
    check("rst_a_tmo",   ifa.timeout_err, 0);
    check("rst_b_valid", ifb.out_valid, 0);
    check("rst_b_data",  ifb.out_data, 0);
    rst_n = 1'b1;
    step();

    // Little-endian pair with consumer always ready: one-cycle valid.
    ifa.out_ready = 1'b1;
    send_a(8'h34);
    check("le_partial_valid", ifa.out_valid, 0);
    send_a(8'h12);
    check("le_valid", ifa.out_valid, 1);
    check("le_data",  ifa.out_data, 64'h1234);
    check("le_count", ifa.fifo_count, 1);
    step();
    check("le_valid_drop", ifa.out_valid, 0);
    check("le_count_after", ifa.fifo_count, 0);
    ifa.out_ready = 1'b0;

    // Big-endian four-byte word.
    send_b(8'hDE); send_b(8'hAD); send_b(8'hBE); send_b(8'hEF);
    check("be_count1", ifb.fifo_count, 1);
    check("be_data",   ifb.out_data, 64'hDEADBEEF);
    ifb.out_ready = 1'b1;
    step();
    ifb.out_ready = 1'b0;
    check("be_count0", ifb.fifo_count, 0);

    // Overflow: five words into a depth-4 FIFO with no consumer.
    for (int i = 0; i < 4; i++) send_word_a(ovf_words[i]);
    check("ovf_full_count", ifa.fifo_count, 4);
    check("ovf_not_yet", ifa.overflow, 0);
    send_word_a(ovf_words[4]);
    check("ovf_count", ifa.fifo_count, 4);
    check("ovf_set", ifa.overflow, 1);
    ifa.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ovf_pop%0d", i), ifa.out_data, 64'(ovf_words[i]));
      step();
    end
    ifa.out_ready = 1'b0;
    check("ovf_drained", ifa.fifo_count, 0);
    check("ovf_sticky", ifa.overflow, 1);
    ifa.overflow_clr = 1'b1;
    step();
    ifa.overflow_clr = 1'b0;
    check("ovf_clr", ifa.overflow, 0);

    // Full FIFO with push and pop in the same cycle.
    for (int i = 0; i < 4; i++) send_word_a(ovf_words[i]);
    send_a(8'hB4);
    ifa.out_ready = 1'b1;
    send_a(8'hB5);
    ifa.out_ready = 1'b0;
    check("pp_count", ifa.fifo_count, 4);
    check("pp_no_ovf", ifa.overflow, 0);
    ifa.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("pp_pop%0d", i), ifa.out_data, 64'(pp_words[i]));
      step();
    end
    ifa.out_ready = 1'b0;
    check("pp_drained", ifa.fifo_count, 0);

    // Timeout: lone byte then silence.
    send_a(8'hAA);
    pulses = 0;
    first  = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (ifa.timeout_err) begin
        pulses++;
        if (first == 0) first = i;
      end
    end
    check("tmo_pulses", 64'(pulses), 1);
    check("tmo_window", 64'((first >= 10) && (first <= 12)), 1);
    check("tmo_no_push", ifa.fifo_count, 0);
    send_a(8'h01);
    send_a(8'h02);
    check("tmo_clean_count", ifa.fifo_count, 1);
    check("tmo_clean_data", ifa.out_data, 64'h0201);
    ifa.out_ready = 1'b1; step(); ifa.out_ready = 1'b0;

    // Flush alone, then flush coincident with a byte.
    send_a(8'h55);
    ifa.flush = 1'b1; step(); ifa.flush = 1'b0;
    ifa.flush = 1'b1; send_a(8'h66); ifa.flush = 1'b0;
    send_a(8'h77);
    send_a(8'h88);
    check("flush_count", ifa.fifo_count, 1);
    check("flush_data", ifa.out_data, 64'h8877);
    ifa.out_ready = 1'b1; step(); ifa.out_ready = 1'b0;
    send_a(8'h11);
    ifa.flush = 1'b1; send_a(8'h22); ifa.flush = 1'b0;
    send_a(8'h33);
    send_a(8'h44);
    check("flush_coinc_count", ifa.fifo_count, 1);
    check("flush_coinc_data", ifa.out_data, 64'h4433);
    ifa.out_ready = 1'b1; step(); ifa.out_ready = 1'b0;

    // Asynchronous reset with two words queued and a partial word pending.
    send_word_a(16'hC1C0);
    send_word_a(16'hC3C2);
    send_a(8'h99);
    check("rst_mid_count_before", ifa.fifo_count, 2);
    rst_n = 1'b0;
    #2;
    check("rst_mid_valid", ifa.out_valid, 0);
    check("rst_mid_count", ifa.fifo_count, 0);
    check("rst_mid_data",  ifa.out_data, 0);
    step();
    rst_n = 1'b1;
    send_a(8'h5A);
    send_a(8'hA5);
    check("rst_clean_count", ifa.fifo_count, 1);
    check("rst_clean_data",  ifa.out_data, 64'hA55A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_word_packer.md
Name: uart_word_packer

Overview:
- Parametrised successor to the two-byte UART word assembler.
- Collects BYTES_PER_WORD received UART bytes into one word, in a selectable byte order.
- Buffers completed words in a small FIFO and presents them to the datapath with a valid/ready handshake.
- Adds flush, inter-byte timeout recovery and overflow reporting.
- Sits between the UART receiver and the weight/input loader.

Parameters:
- BYTES_PER_WORD, 2, number of bytes per output word; legal range 1..8.
- FIFO_DEPTH, 4, number of output word entries; power of 2, minimum 2.
- BIG_ENDIAN, 0, byte order: 0 = first byte goes to LSB; 1 = first byte goes to MSB.
- TIMEOUT_CYCLES, 0, clock cycles allowed between bytes of one word; 0 disables the timeout.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- rx_valid  input  1  one-cycle strobe: rx_data holds a new byte.
- rx_data  input  8  received byte.
- flush  input  1  synchronous; discards the partially assembled word.
- out_data  output  8*BYTES_PER_WORD  word at the FIFO head.
- out_valid  output  1  FIFO not empty.
- out_ready  input  1  consumer accepts out_data this cycle.
- fifo_count  output  clog2(FIFO_DEPTH)+1  number of words stored.
- overflow  output  1  sticky; a completed word was dropped.
- overflow_clr  input  1  clears overflow.
- timeout_err  output  1  one-cycle pulse when a partial word is discarded by timeout.

Behaviour:
- Reset values:
  - out_valid=0, out_data=0, fifo_count=0, overflow=0, timeout_err=0.
  - Byte index=0, timeout counter=0, assembly register=0.
  - FIFO pointers=0.
- Assembly:
  - Byte index k runs 0..BYTES_PER_WORD-1 and advances on each rx_valid.
  - BIG_ENDIAN=0: byte k is written to bits [8k+7:8k].
  - BIG_ENDIAN=1: byte k is written to bits [8(B-1-k)+7 : 8(B-1-k)].
  - Each position is overwritten on every word, so the assembly register is not cleared between words.
- Word completion:
  - On rx_valid with k=B-1, the completed word (assembly register merged with this byte) is pushed into the FIFO in the same cycle. k wraps to 0.
  - Latency: last byte strobe in cycle N gives out_valid=1 and the word on out_data in cycle N+1, when the FIFO was empty.
  - BYTES_PER_WORD=1: every rx_valid pushes a word.
- FIFO:
  - out_data always shows the head entry. out_valid = (fifo_count != 0).
  - Pop occurs when out_valid && out_ready.
  - Push and pop in the same cycle are both performed; fifo_count is unchanged.
  - When full with a pop in the same cycle, the push is accepted (no overflow).
  - Pointers wrap modulo FIFO_DEPTH.
- Overflow:
  - A completed word arriving while the FIFO is full and no pop occurs is dropped; overflow is set.
  - Stored words are untouched.
  - Set has priority over overflow_clr in the same cycle.
- Timeout (TIMEOUT_CYCLES>0 only):
  - The counter runs only while k>0 and resets on every rx_valid.
  - When it reaches TIMEOUT_CYCLES with no byte: k becomes 0, timeout_err pulses for 1 cycle, and the counter clears.
  - If rx_valid arrives in the same cycle as expiry, the byte wins: it is accepted normally and there is no timeout.
- Flush:
  - Sets k=0 and clears the timeout counter; no word is pushed.
  - flush has priority over rx_valid in the same cycle; that byte is discarded.
  - FIFO contents and overflow are unaffected.
- Reset asserted mid-word or mid-FIFO: all state returns to reset values immediately, and partial and stored words are lost.
- rx_valid is a single-cycle strobe from the receiver. Back-to-back strobes on consecutive cycles must be handled.

Test Plan:
- B=2, LE: bytes 0x34 then 0x12, out_ready=1 -> out_data=0x1234 with a 1-cycle out_valid, one cycle after the second byte.
- B=4, BIG_ENDIAN=1: bytes 0xDE,0xAD,0xBE,0xEF -> out_data=0xDEADBEEF; fifo_count goes 0→1→0 after a handshake.
- DEPTH=4, out_ready=0, send 5 words -> fifo_count=4, overflow=1, and words 1-4 are popped intact in order. Then:
  - overflow_clr -> overflow=0.
  - Full FIFO with push and pop in the same cycle -> no overflow.
- TIMEOUT_CYCLES=10, B=2: byte 0xAA then silence -> timeout_err pulses once after 10 cycles. Then 0x01, 0x02 -> 0x0201, not 0x01AA.
- flush between byte 0x55 and byte 0x66, then bytes 0x77, 0x88 -> single word 0x8877. Then flush coincident with rx_valid -> that byte is ignored.
- Assert rst_n low after the first byte with two words queued -> all outputs return to reset values, and the next two bytes form a clean word.
